// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the bitty core.
//
// Holds a 2**ADDR_W x 16 program RAM (written while idle or halted) and a program counter.
// After start, each word is read from RAM, presented on d_instr with run held high until the
// core pulses core_done, then the PC advances. A 16'hFFFF word halts execution; a watchdog
// halts with a sticky timeout flag if the core never answers.
//
// Optional feature (macro FETCH_BRANCH_EN): words with bits [1:0] == 2'b10 are conditional
// branches resolved locally against the last core result and never issued to the core.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start               - begin execution at PC 0 (idle/halt only)
//   prog_we/addr/wdata  - program RAM write port (idle/halt only)
//   core_done           - completion pulse from the core
//   core_result         - core output, captured on core_done
//   d_instr, run        - registered instruction and execute request to the core
//   pc                  - current program counter
//   busy, halted        - state decodes (fetch/load/exec, halt)
//   timeout             - sticky watchdog flag
//   retired             - completed-instruction count (wraps)
module fetch_unit #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_wdata,
  input  logic              core_done,
  input  logic [15:0]       core_result,
  output logic [15:0]       d_instr,
  output logic              run,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              timeout,
  output logic [15:0]       retired
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam int unsigned WdW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [15:0] HaltWord = 16'hFFFF;

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StExec, StHalt} state_e;

  state_e            state_q, state_d;
  logic [15:0]       d_instr_q, d_instr_d;
  logic              run_q, run_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       retired_q, retired_d;
  logic [WdW-1:0]    wd_q, wd_d;

  logic [15:0] mem [Depth];
  logic [15:0] mem_q;
  logic        idle_or_halt;

  assign idle_or_halt = (state_q == StIdle) || (state_q == StHalt);

  // Program RAM: write port active only while idle/halted, so a write in the same cycle as
  // start lands before the first FETCH reads it.
  always_ff @(posedge clk) begin
    if (!reset && prog_we && idle_or_halt) begin
      mem[prog_addr] <= prog_wdata;
    end
    if (state_q == StFetch) begin
      mem_q <= mem[pc_q];
    end
  end

`ifdef FETCH_BRANCH_EN
  logic [15:0]       last_result_q;
  logic              is_branch;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;

  assign is_branch = (mem_q[1:0] == 2'b10);
  assign br_target = mem_q[ADDR_W+3:4];

  always_comb begin
    br_taken = 1'b0;
    case (mem_q[3:2])
      2'b00:   br_taken = (last_result_q == 16'd0);
      2'b01:   br_taken = (last_result_q != 16'd0);
      2'b10:   br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_result_q <= '0;
    end else if (state_q == StExec && core_done) begin
      last_result_q <= core_result;
    end
  end
`else
  // Without branches the core result has no consumer in this stage.
  logic unused_core_result;
  assign unused_core_result = ^core_result;
`endif

  always_comb begin
    state_d   = state_q;
    d_instr_d = d_instr_q;
    run_d     = run_q;
    pc_d      = pc_q;
    timeout_d = timeout_q;
    retired_d = retired_q;
    wd_d      = wd_q;
    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          pc_d      = '0;
          timeout_d = 1'b0;
          retired_d = '0;
          state_d   = StFetch;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        if (mem_q == HaltWord) begin
          state_d = StHalt;
`ifdef FETCH_BRANCH_EN
        end else if (is_branch) begin
          pc_d      = br_taken ? br_target : pc_q + ADDR_W'(1);
          retired_d = retired_q + 16'd1;
          state_d   = StFetch;
`endif
        end else begin
          d_instr_d = mem_q;
          run_d     = 1'b1;
          wd_d      = '0;
          state_d   = StExec;
        end
      end
      StExec: begin
        // core_done wins over a watchdog expiry in the same cycle.
        if (core_done) begin
          run_d     = 1'b0;
          retired_d = retired_q + 16'd1;
          pc_d      = pc_q + ADDR_W'(1);
          state_d   = StFetch;
        end else if (TIMEOUT != 0 && wd_q == WdW'(TIMEOUT - 1)) begin
          run_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = StHalt;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      d_instr_q <= '0;
      run_q     <= 1'b0;
      pc_q      <= '0;
      timeout_q <= 1'b0;
      retired_q <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      d_instr_q <= d_instr_d;
      run_q     <= run_d;
      pc_q      <= pc_d;
      timeout_q <= timeout_d;
      retired_q <= retired_d;
      wd_q      <= wd_d;
    end
  end

  assign d_instr = d_instr_q;
  assign run     = run_q;
  assign pc      = pc_q;
  assign timeout = timeout_q;
  assign retired = retired_q;
  assign busy    = (state_q == StFetch) || (state_q == StLoad) || (state_q == StExec);
  assign halted  = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: the bench plays the core, and a program-level reference model
// (memory image, PC, retired count, last result) predicts every issued word, run gap,
// halt point and watchdog expiry.
module tb_fetch_unit;

  localparam int unsigned AW    = 4;
  localparam int unsigned TO    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_wdata;
  logic          core_done;
  logic [15:0]   core_result;
  logic [15:0]   d_instr;
  logic          run;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic          timeout;
  logic [15:0]   retired;

  fetch_unit #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .core_done  (core_done),
    .core_result(core_result),
    .d_instr    (d_instr),
    .run        (run),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .timeout    (timeout),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [15:0]   mmem [DEPTH];
  logic [AW-1:0] mpc;
  logic [15:0]   mret;
  logic [15:0]   mlast;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_branch(input logic [15:0] w);
`ifdef FETCH_BRANCH_EN
    return w[1:0] == 2'b10;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [AW-1:0] branch_next(input logic [15:0] w);
    bit taken;
    case (w[3:2])
      2'b00:   taken = (mlast == 0);
      2'b01:   taken = (mlast != 0);
      2'b10:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken ? w[AW+3:4] : mpc + AW'(1);
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w == 16'hFFFF) w = 16'h0000;
`ifdef FETCH_BRANCH_EN
    if (w[1:0] == 2'b10) w[1:0] = 2'b00;
`endif
    return w;
  endfunction

  task automatic load(input int addr, input logic [15:0] data);
    prog_we    = 1'b1;
    prog_addr  = AW'(addr);
    prog_wdata = data;
    @(negedge clk);
    prog_we = 1'b0;
    mmem[addr] = data;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mpc  = '0;
    mret = '0;
  endtask

  // Act as the core until the model predicts a halt or max_issue words have completed.
  task automatic run_prog(input int max_issue, input bit zero_res, input int max_delay,
                          input bit inj);
    int issued = 0;
    int skipped;
    int gap;
    int d;
    bit stable;
    bit saw_run;
    logic [15:0] w;
    logic [15:0] res;
    forever begin
      if (issued == max_issue) return;
      skipped = 0;
      w = mmem[mpc];
      while (w != 16'hFFFF && is_branch(w) && skipped < 64) begin
        mpc  = branch_next(w);
        mret = mret + 16'd1;
        skipped++;
        w = mmem[mpc];
      end
      gap = 0;
      saw_run = 1'b0;
      if (w == 16'hFFFF) begin
        while (!halted && gap < 40) begin
          if (run) saw_run = 1'b1;
          gap++;
          @(negedge clk);
        end
        chk("halt_reached", halted, 1);
        chk("halt_gap", gap, 2 + 2 * skipped);
        chk("halt_no_run", saw_run, 0);
        chk("halt_pc", pc, mpc);
        chk("halt_retired", retired, mret);
        chk("halt_busy", busy, 0);
        return;
      end
      while (!run && gap < 40) begin
        gap++;
        @(negedge clk);
      end
      chk("issue_run", run, 1);
      chk("issue_gap", gap, 2 + 2 * skipped);
      chk("issue_instr", d_instr, w);
      chk("issue_pc", pc, mpc);
      chk("issue_busy", busy, 1);
      d = $urandom_range(max_delay, 0);
      stable = 1'b1;
      for (int i = 0; i < d; i++) begin
        if (inj && i == 0) begin
          // start and program writes while busy must have no effect
          start      = 1'b1;
          prog_we    = 1'b1;
          prog_addr  = AW'($urandom);
          prog_wdata = 16'($urandom);
        end
        @(negedge clk);
        start   = 1'b0;
        prog_we = 1'b0;
        if (!(run === 1'b1 && d_instr === w)) stable = 1'b0;
      end
      chk("hold_stable", stable, 1);
      res = zero_res ? 16'd0 : 16'($urandom);
      core_done   = 1'b1;
      core_result = res;
      @(negedge clk);
      core_done = 1'b0;
      mret  = mret + 16'd1;
      mlast = res;
      mpc   = mpc + AW'(1);
      issued++;
      chk("done_run_low", run, 0);
      chk("done_retired", retired, mret);
    end
  endtask

  initial begin
    int gap;
    int cyc;
    int len;
    reset       = 1'b1;
    start       = 1'b0;
    prog_we     = 1'b0;
    prog_addr   = '0;
    prog_wdata  = '0;
    core_done   = 1'b0;
    core_result = '0;
    mpc   = '0;
    mret  = '0;
    mlast = '0;
    for (int i = 0; i < DEPTH; i++) mmem[i] = 16'hFFFF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // Fill RAM so the model image matches the DUT from the start.
    for (int i = 0; i < DEPTH; i++) load(i, 16'hFFFF);

    chk("rst_d_instr", d_instr, 0);
    chk("rst_run", run, 0);
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_retired", retired, 0);

    // core_done outside EXEC is ignored.
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("idle_done_retired", retired, 0);
    chk("idle_done_busy", busy, 0);

    // Single instruction then halt.
    load(0, 16'h0001);
    load(1, 16'hFFFF);
    do_start();
    run_prog(100, 1'b0, 1, 1'b0);

    // Four instructions plus halt.
    for (int i = 0; i < 4; i++) load(i, rand_word());
    load(4, 16'hFFFF);
    do_start();
    run_prog(100, 1'b0, 3, 1'b0);
    chk("four_pc", pc, 4);
    chk("four_retired", retired, 4);

    // Random programs with ignored-input injection while busy.
    for (int t = 0; t < 6; t++) begin
      len = $urandom_range(DEPTH - 2, 1);
      for (int i = 0; i < len; i++) load(i, rand_word());
      load(len, 16'hFFFF);
      do_start();
      run_prog(100, 1'b0, 5, 1'b1);
    end

    // core_done while halted is ignored.
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("halt_done_retired", retired, mret);
    chk("halt_done_pc", pc, mpc);

    // Write and start in the same cycle: the new word is fetched.
    start      = 1'b1;
    prog_we    = 1'b1;
    prog_addr  = '0;
    prog_wdata = 16'h1234;
    @(negedge clk);
    start   = 1'b0;
    prog_we = 1'b0;
    mmem[0] = 16'h1234;
    mpc  = '0;
    mret = '0;
    run_prog(100, 1'b0, 2, 1'b0);

    // No halt word anywhere: PC wraps from DEPTH-1 to 0.
    for (int i = 0; i < DEPTH; i++) load(i, rand_word());
    do_start();
    run_prog(DEPTH + 1, 1'b0, 2, 1'b0);
    chk("wrap_retired", retired, DEPTH + 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mlast = '0;

    // Watchdog: second instruction never completes.
    load(0, rand_word());
    load(1, rand_word());
    load(2, 16'hFFFF);
    do_start();
    run_prog(1, 1'b0, 3, 1'b0);
    gap = 0;
    while (!run && gap < 40) begin
      gap++;
      @(negedge clk);
    end
    chk("wd_issue", d_instr, mmem[1]);
    cyc = 0;
    while (run && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    chk("wd_run_cycles", cyc, TO);
    chk("wd_timeout", timeout, 1);
    chk("wd_halted", halted, 1);
    chk("wd_pc", pc, 1);
    chk("wd_retired", retired, 1);

    // Reset mid-EXEC, then rerun the same program.
    for (int i = 0; i < 5; i++) load(i, rand_word());
    load(5, 16'hFFFF);
    do_start();
    chk("start_clears_timeout", timeout, 0);
    gap = 0;
    while (!run && gap < 40) begin
      gap++;
      @(negedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mlast = '0;
    chk("mid_rst_run", run, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_retired", retired, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_halted", halted, 0);
    do_start();
    run_prog(100, 1'b0, 4, 1'b0);
    chk("rerun_retired", retired, 5);

`ifdef FETCH_BRANCH_EN
    // cond 00 with zero result: taken to 5, mem[2] skipped.
    load(0, 16'h1230);
    load(1, 16'h0052);
    load(2, 16'h2221);
    load(3, 16'hFFFF);
    load(5, 16'h5551);
    load(6, 16'hFFFF);
    do_start();
    run_prog(100, 1'b1, 2, 1'b0);
    chk("br00_pc", pc, 6);
    // cond 01 with zero result: not taken, mem[2] issues.
    load(1, 16'h0056);
    do_start();
    run_prog(100, 1'b1, 2, 1'b0);
    chk("br01_pc", pc, 3);
    // cond 10 and 11 with random results.
    load(1, 16'h005A);
    do_start();
    run_prog(100, 1'b0, 2, 1'b0);
    load(1, 16'h005E);
    do_start();
    run_prog(100, 1'b0, 2, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
